// File: rtl/uart_pkg.sv
// Shared state encoding, parity constants and frame-length helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Serial bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity_mode, input int stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int parity_mode, input int stop_bits);
    return clks_per_bit * frame_bits(data_bits, parity_mode, stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO buffering words for the UART transmitter; level tells full from empty.
module uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; level and pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered, parametrised UART transmitter with valid/ready input and zero-gap back-to-back frames.
// Optional line-break generation (send_break input, BREAK state) is enabled by defining UART_TX_BREAK_EN.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                        send_break,
`endif
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS));

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] MARK_IDX  = IDX_W'(1);

  uart_state_t          state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;

  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 break_req;
  logic                 bit_end;
  logic                 sched;
  logic                 pop;

`ifdef UART_TX_BREAK_EN
  assign break_req = send_break;
`else
  assign break_req = 1'b0;
`endif

  uart_tx_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (tx_valid),
    .pop     (pop),
    .wr_data (tx_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // A scheduling point is idle, the end of the last stop bit, or the end of mark-after-break;
  // deciding the next frame there is what gives zero-gap back-to-back frames.
  assign bit_end = (baud_cnt == '0);
  assign sched   = (state == IDLE) ||
                   (bit_end && (((state == STOP) && (bit_idx == LAST_STOP)) ||
                                ((state == BREAK) && (bit_idx == MARK_IDX))));
  assign pop     = sched && !break_req && !fifo_empty;

  assign tx_ready = !fifo_full;
  assign busy     = (state != IDLE) || (fifo_level != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
    end else if (sched) begin
      if (break_req) begin
        state   <= BREAK;
        bit_idx <= '0;
        tx      <= 1'b0;
      end else if (!fifo_empty) begin
        state      <= START;
        baud_cnt   <= CNT_MAX;
        bit_idx    <= '0;
        shift_reg  <= fifo_rd_data;
        parity_bit <= (PARITY_MODE == PARITY_ODD) ? ~(^fifo_rd_data) : ^fifo_rd_data;
        tx         <= 1'b0;
      end else begin
        state <= IDLE;
        tx    <= 1'b1;
      end
    end else begin
      case (state)
        START: begin
          if (bit_end) begin
            state     <= DATA;
            baud_cnt  <= CNT_MAX;
            bit_idx   <= '0;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= CNT_MAX;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY_MODE != PARITY_NONE) begin
                state <= PARITY;
                tx    <= parity_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            baud_cnt <= CNT_MAX;
            bit_idx  <= '0;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          // Only non-final stop periods land here; the final one is a scheduling point.
          if (bit_end) begin
            baud_cnt <= CNT_MAX;
            bit_idx  <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          // bit_idx 0 holds the line low; 1 times the mark-after-break period.
          if (bit_idx == '0) begin
            if (!break_req) begin
              bit_idx  <= MARK_IDX;
              baud_cnt <= CNT_MAX;
              tx       <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench for uart_tx_fifo_param: stimulus queues expected line waveforms, a monitor checks them.
module tb_uart_tx_fifo_param;

  localparam int CPB = 4;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          cyc_per;
    int          id;
    int          exp_start;   // -1 don't care, -2 must follow previous frame with no gap
    bit          idle_after;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        send_break;
  logic [3:0]  valid_w;
  logic [8:0]  data_w [4];
  wire  [3:0]  tx_w;
  wire  [3:0]  busy_w;
  wire  [3:0]  ready_w;
  wire  [11:0] level_flat;

  exp_t exp_q[$];
  exp_t f;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;
  bit   mon_active = 1'b0;
  int   prev_end = -100;
  int   m;
  int   s;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

`ifdef UART_TX_BREAK_EN
  `define TB_BRK .send_break(send_break),
`else
  `define TB_BRK
`endif

  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clock(clock), .reset(reset), .tx_data(data_w[0][7:0]), .tx_valid(valid_w[0]), `TB_BRK
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_level(level_flat[2:0]));
  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clock(clock), .reset(reset), .tx_data(data_w[1][7:0]), .tx_valid(valid_w[1]), `TB_BRK
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_level(level_flat[5:3]));
  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clock(clock), .reset(reset), .tx_data(data_w[2][7:0]), .tx_valid(valid_w[2]), `TB_BRK
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_level(level_flat[8:6]));
  uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clock(clock), .reset(reset), .tx_data(data_w[3][6:0]), .tx_valid(valid_w[3]), `TB_BRK
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_level(level_flat[11:9]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 8N1 frame, start bit first: {stop, data, start}.
  function automatic logic [31:0] f8n1(input logic [7:0] d);
    return {22'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic exp_t mk(input int id, input logic [31:0] bits, input int nbits, input int cyc_per,
                              input int exp_start, input bit idle_after);
    exp_t e;
    e.bits = bits; e.nbits = nbits; e.cyc_per = cyc_per;
    e.id = id; e.exp_start = exp_start; e.idle_after = idle_after;
    return e;
  endfunction

  // Called just after a negedge; leaves tx_valid high for the caller to drop or reuse.
  task automatic push_word(input int id, input logic [8:0] d);
    int n = 0;
    data_w[id]  = d;
    valid_w[id] = 1'b1;
    while (!ready_w[id] && n < 200) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("u%0d_push_ready", id), {31'b0, ready_w[id]}, 32'd1);
    @(negedge clock);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !mon_active && busy_w == 4'b0) break;
      @(negedge clock);
    end
    check("drain_pending", exp_q.size() + int'(mon_active) + int'(busy_w != 4'b0), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  // Monitor: waits for the head entry's line to go low, then compares every cycle of the waveform.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && exp_q.size() > 0 && tx_w[exp_q[0].id] == 1'b0) begin
        mon_active = 1'b1;
        f = exp_q.pop_front();
        s = cyc;
        if (f.exp_start == -2)
          check($sformatf("u%0d_gap", f.id), s, prev_end);
        else if (f.exp_start >= 0)
          check($sformatf("u%0d_start_latency", f.id), s, f.exp_start);
        for (int b = 0; b < f.nbits; b++) begin
          for (int c = 0; c < f.cyc_per; c++) begin
            if (b != 0 || c != 0) @(negedge clock);
            check($sformatf("u%0d_tx_bit%0d", f.id, b), {31'b0, tx_w[f.id]}, {31'b0, f.bits[b]});
            check($sformatf("u%0d_busy_bit%0d", f.id, b), {31'b0, busy_w[f.id]}, 32'd1);
          end
        end
        prev_end = s + f.nbits * f.cyc_per;
        if (f.idle_after) begin
          @(negedge clock);
          check($sformatf("u%0d_busy_after", f.id), {31'b0, busy_w[f.id]}, 32'd0);
          check($sformatf("u%0d_tx_after", f.id), {31'b0, tx_w[f.id]}, 32'd1);
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    send_break = 1'b0;
    valid_w    = '0;
    for (int i = 0; i < 4; i++) data_w[i] = '0;
    repeat (3) @(negedge clock);
    check("reset_tx", {31'b0, tx_w[0]}, 32'd1);
    check("reset_busy", {31'b0, busy_w[0]}, 32'd0);
    check("reset_level", {29'b0, level_flat[2:0]}, 32'd0);
    check("reset_ready", {31'b0, ready_w[0]}, 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 0xA5, 8N1: 0,1,0,1,0,0,1,0,1,1 with tx low one edge after acceptance.
    exp_q.push_back(mk(0, 32'b11_0100_1010, 10, CPB, cyc + 2, 1'b1));
    push_word(0, 9'h0A5);
    valid_w[0] = 1'b0;
    wait_drain();

    // 0x07 with even parity (parity bit 1) and odd parity (parity bit 0).
    exp_q.push_back(mk(1, 32'b110_0000_1110, 11, CPB, cyc + 2, 1'b1));
    push_word(1, 9'h007);
    valid_w[1] = 1'b0;
    wait_drain();
    exp_q.push_back(mk(2, 32'b100_0000_1110, 11, CPB, cyc + 2, 1'b1));
    push_word(2, 9'h007);
    valid_w[2] = 1'b0;
    wait_drain();

    // 7 data bits, 2 stop bits: 0xD5 truncates to 0x55.
    exp_q.push_back(mk(3, 32'b11_1010_1010, 10, CPB, cyc + 2, 1'b1));
    push_word(3, 9'h0D5);
    valid_w[3] = 1'b0;
    wait_drain();

    // Five back-to-back words: first goes on the line, four fill the FIFO, a sixth is dropped.
    exp_q.push_back(mk(0, f8n1(8'h11), 10, CPB, cyc + 2, 1'b0));
    exp_q.push_back(mk(0, f8n1(8'h22), 10, CPB, -2, 1'b0));
    exp_q.push_back(mk(0, f8n1(8'h3C), 10, CPB, -2, 1'b0));
    exp_q.push_back(mk(0, f8n1(8'hF0), 10, CPB, -2, 1'b0));
    exp_q.push_back(mk(0, f8n1(8'h81), 10, CPB, -2, 1'b1));
    push_word(0, 9'h011);
    push_word(0, 9'h022);
    push_word(0, 9'h03C);
    push_word(0, 9'h0F0);
    push_word(0, 9'h081);
    check("full_ready", {31'b0, ready_w[0]}, 32'd0);
    check("full_level", {29'b0, level_flat[2:0]}, 32'd4);
    data_w[0] = 9'h0EE;
    repeat (3) @(negedge clock);
    check("full_drop_level", {29'b0, level_flat[2:0]}, 32'd4);
    valid_w[0] = 1'b0;
    wait_drain();

    // Reset during data bit 3 with two words queued.
    mon_en = 1'b0;
    m = cyc;
    push_word(0, 9'h0AA);
    push_word(0, 9'h055);
    push_word(0, 9'h00F);
    valid_w[0] = 1'b0;
    wait_until(m + 2 + 17);
    check("pre_reset_level", {29'b0, level_flat[2:0]}, 32'd2);
    check("pre_reset_tx_bit3", {31'b0, tx_w[0]}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_reset_tx", {31'b0, tx_w[0]}, 32'd1);
    check("mid_reset_level", {29'b0, level_flat[2:0]}, 32'd0);
    check("mid_reset_busy", {31'b0, busy_w[0]}, 32'd0);
    check("mid_reset_ready", {31'b0, ready_w[0]}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("post_reset_tx_idle", {31'b0, tx_w[0]}, 32'd1);
    end
    mon_en = 1'b1;
    exp_q.push_back(mk(0, f8n1(8'h96), 10, CPB, cyc + 2, 1'b1));
    push_word(0, 9'h096);
    valid_w[0] = 1'b0;
    wait_drain();

`ifdef UART_TX_BREAK_EN
    // Break raised mid-frame for 50 cycles: frame completes, 21 low cycles, 4 mark cycles, then queued data.
    m = cyc;
    exp_q.push_back(mk(0, f8n1(8'h5A), 10, CPB, m + 2, 1'b0));
    exp_q.push_back(mk(0, 32'h01E0_0000, 25, 1, -2, 1'b0));
    exp_q.push_back(mk(0, f8n1(8'hC3), 10, CPB, -2, 1'b0));
    push_word(0, 9'h05A);
    push_word(0, 9'h0C3);
    valid_w[0] = 1'b0;
    wait_until(m + 2 + 10);
    send_break = 1'b1;
    wait_until(m + 2 + 45);
    exp_q.push_back(mk(0, f8n1(8'h69), 10, CPB, -2, 1'b1));
    push_word(0, 9'h069);
    valid_w[0] = 1'b0;
    check("break_push_level", {29'b0, level_flat[2:0]}, 32'd2);
    wait_until(m + 2 + 60);
    send_break = 1'b0;
    wait_drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
